// File: rtl/layer_sequencer.sv
// layer_sequencer
//   Top-level scheduler for a stack of nlayers layer_top instances. A run first
//   enables the computation pass of every layer from layer 0 up to nlayers-1,
//   then the sumcheck pass from nlayers-1 back down to 0. Each step is
//   triggered by the active layer's ready pulse; completion is reported with
//   ready_pulse/ready.
//
//   Optional feature macro: LAYER_SEQ_WDOG_EN
//     When defined, a per-layer watchdog moves the sequencer to an ERR state if
//     the active layer does not answer within wdog_cycles. When undefined the
//     sequencer waits indefinitely and err is tied low.
//
// Parameters
//   nlayers      number of layers sequenced (>= 1)
//   nlbits       layer index width, derived from nlayers; must not be overridden
//   wdog_cycles  per-layer timeout in cycles (watchdog builds only)
//
// Ports
//   clk                 in   clock
//   rstb                in   asynchronous active-low reset
//   start               in   begin a full compute+sumcheck run (pulse)
//   id_in               in   computation id, captured on an accepted start
//   comp_ready_pulse    in   per-layer computation-done pulses
//   sumchk_ready_pulse  in   per-layer sumcheck-done pulses
//   en_comp             out  one-hot 1-cycle computation enable
//   en_sumchk           out  one-hot 1-cycle sumcheck enable
//   id                  out  registered id, fanned out to every layer
//   cur_layer           out  index of the active layer
//   busy                out  run in progress
//   ready_pulse         out  1-cycle pulse when a run completes
//   ready               out  high from completion until the next accepted start
//   err                 out  watchdog fired
module layer_sequencer #(
  parameter int nlayers     = 4,
  parameter int nlbits      = (nlayers > 1) ? $clog2(nlayers) : 1,
  parameter int wdog_cycles = 4096
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               start,
  input  logic [31:0]        id_in,
  input  logic [nlayers-1:0] comp_ready_pulse,
  input  logic [nlayers-1:0] sumchk_ready_pulse,
  output logic [nlayers-1:0] en_comp,
  output logic [nlayers-1:0] en_sumchk,
  output logic [31:0]        id,
  output logic [nlbits-1:0]  cur_layer,
  output logic               busy,
  output logic               ready_pulse,
  output logic               ready,
  output logic               err
);

  localparam int nlbits_exp = (nlayers > 1) ? $clog2(nlayers) : 1;
  localparam logic [nlbits-1:0] last_layer = nlbits'(nlayers - 1);

  // Elaboration-time guards on the parameter set.
  if (nlayers < 1) begin : g_bad_nlayers
    $error("layer_sequencer: nlayers must be at least 1");
  end
  if (nlbits != nlbits_exp) begin : g_bad_nlbits
    $error("layer_sequencer: nlbits is derived from nlayers and must not be overridden");
  end
  if (wdog_cycles < 2) begin : g_bad_wdog
    $error("layer_sequencer: wdog_cycles must be at least 2");
  end

`ifdef LAYER_SEQ_WDOG_EN
  typedef enum logic [2:0] {IDLE, C_EN, C_WAIT, S_EN, S_WAIT, DONE, ERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, C_EN, C_WAIT, S_EN, S_WAIT, DONE} state_t;
`endif

  state_t             state, state_nxt;
  logic [nlbits-1:0]  cur_nxt;
  logic [31:0]        id_nxt;
  logic               busy_nxt;
  logic               ready_nxt;
  logic               ready_pulse_nxt;
  logic [nlayers-1:0] en_comp_nxt;
  logic [nlayers-1:0] en_sumchk_nxt;
  logic [nlbits-1:0]  layer_up;
  logic [nlbits-1:0]  layer_down;
  logic               comp_hit;
  logic               sumchk_hit;

  function automatic logic [nlayers-1:0] layer_bit(input logic [nlbits-1:0] idx);
    return nlayers'(1) << idx;
  endfunction

  assign layer_up   = cur_layer + nlbits'(1);
  assign layer_down = cur_layer - nlbits'(1);

  // Only the active layer's bit of the current phase counts; everything else
  // on the ready vectors is ignored.
  assign comp_hit   = |(comp_ready_pulse & layer_bit(cur_layer));
  assign sumchk_hit = |(sumchk_ready_pulse & layer_bit(cur_layer));

`ifdef LAYER_SEQ_WDOG_EN
  logic [31:0] wdog_cnt, wdog_nxt;
  logic        wdog_expired;
  logic        err_q, err_nxt;

  // The counter holds the number of completed WAIT cycles; the timeout fires
  // in the WAIT cycle where it would reach wdog_cycles-1.
  assign wdog_expired = (wdog_cnt + 32'd1) >= 32'(wdog_cycles - 1);
  assign err          = err_q;
`else
  assign err = 1'b0;
`endif

  // Next-state and next-output decode. Every output is registered from these
  // values, so enables appear the cycle after the event that causes them.
  always_comb begin
    state_nxt       = state;
    cur_nxt         = cur_layer;
    id_nxt          = id;
    busy_nxt        = busy;
    ready_nxt       = ready;
    ready_pulse_nxt = 1'b0;
    en_comp_nxt     = '0;
    en_sumchk_nxt   = '0;
`ifdef LAYER_SEQ_WDOG_EN
    err_nxt         = err_q;
    wdog_nxt        = wdog_cnt;
`endif

    case (state)
      C_EN, C_WAIT: begin
        // A pulse already in the enable cycle advances exactly like one in WAIT.
        if (comp_hit) begin
          if (cur_layer != last_layer) begin
            cur_nxt     = layer_up;
            state_nxt   = C_EN;
            en_comp_nxt = layer_bit(layer_up);
          end else begin
            state_nxt     = S_EN;
            en_sumchk_nxt = layer_bit(cur_layer);
          end
        end else if (state == C_EN) begin
          state_nxt = C_WAIT;
`ifdef LAYER_SEQ_WDOG_EN
          wdog_nxt  = '0;
        end else if (wdog_expired) begin
          state_nxt = ERR;
          err_nxt   = 1'b1;
          busy_nxt  = 1'b0;
        end else begin
          wdog_nxt = wdog_cnt + 32'd1;
`endif
        end
      end

      S_EN, S_WAIT: begin
        if (sumchk_hit) begin
          if (cur_layer != '0) begin
            cur_nxt       = layer_down;
            state_nxt     = S_EN;
            en_sumchk_nxt = layer_bit(layer_down);
          end else begin
            state_nxt       = DONE;
            ready_pulse_nxt = 1'b1;
            ready_nxt       = 1'b1;
            busy_nxt        = 1'b0;
          end
        end else if (state == S_EN) begin
          state_nxt = S_WAIT;
`ifdef LAYER_SEQ_WDOG_EN
          wdog_nxt  = '0;
        end else if (wdog_expired) begin
          state_nxt = ERR;
          err_nxt   = 1'b1;
          busy_nxt  = 1'b0;
        end else begin
          wdog_nxt = wdog_cnt + 32'd1;
`endif
        end
      end

      // A start arriving in the completion cycle is deliberately dropped.
      DONE: state_nxt = IDLE;

      // IDLE (and ERR when present): only an accepted start leaves here.
      default: begin
        if (start) begin
          state_nxt   = C_EN;
          id_nxt      = id_in;
          cur_nxt     = '0;
          busy_nxt    = 1'b1;
          ready_nxt   = 1'b0;
          en_comp_nxt = layer_bit('0);
`ifdef LAYER_SEQ_WDOG_EN
          err_nxt     = 1'b0;
`endif
        end
      end
    endcase
  end

  // State and output registers; reset aborts any run immediately.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state       <= IDLE;
      cur_layer   <= '0;
      id          <= '0;
      busy        <= 1'b0;
      ready       <= 1'b0;
      ready_pulse <= 1'b0;
      en_comp     <= '0;
      en_sumchk   <= '0;
`ifdef LAYER_SEQ_WDOG_EN
      err_q       <= 1'b0;
      wdog_cnt    <= '0;
`endif
    end else begin
      state       <= state_nxt;
      cur_layer   <= cur_nxt;
      id          <= id_nxt;
      busy        <= busy_nxt;
      ready       <= ready_nxt;
      ready_pulse <= ready_pulse_nxt;
      en_comp     <= en_comp_nxt;
      en_sumchk   <= en_sumchk_nxt;
`ifdef LAYER_SEQ_WDOG_EN
      err_q       <= err_nxt;
      wdog_cnt    <= wdog_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer
//   Bench for layer_sequencer. Two instances are exercised: a three-layer stack
//   and a single-layer stack. Behavioural layer models answer each enable a
//   programmable number of cycles later. Every run pushes its expected enable
//   and completion events (kind, layer, cycle) onto a queue; monitors pop and
//   compare as the sequencer emits them.
module tb_layer_sequencer;

  typedef struct packed {
    logic [1:0] kind;
    int         layer;
    int         at;
  } ev_t;

  logic clk = 1'b0;
  logic rstb = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Three-layer instance
  logic        start3 = 1'b0;
  logic [31:0] id_in3 = '0;
  logic [2:0]  comp_rdy3, sum_rdy3;
  logic [2:0]  en_comp3, en_sum3;
  logic [31:0] id3;
  logic [1:0]  cur3;
  logic        busy3, rp3, ready3, err3;

  // Single-layer instance
  logic        start1 = 1'b0;
  logic [31:0] id_in1 = '0;
  logic [0:0]  comp_rdy1, sum_rdy1;
  logic [0:0]  en_comp1, en_sum1;
  logic [31:0] id1;
  logic [0:0]  cur1;
  logic        busy1, rp1, ready1, err1;

  layer_sequencer #(.nlayers(3), .wdog_cycles(16)) dut3 (
    .clk(clk), .rstb(rstb), .start(start3), .id_in(id_in3),
    .comp_ready_pulse(comp_rdy3), .sumchk_ready_pulse(sum_rdy3),
    .en_comp(en_comp3), .en_sumchk(en_sum3), .id(id3), .cur_layer(cur3),
    .busy(busy3), .ready_pulse(rp3), .ready(ready3), .err(err3)
  );

  layer_sequencer #(.nlayers(1), .wdog_cycles(16)) dut1 (
    .clk(clk), .rstb(rstb), .start(start1), .id_in(id_in1),
    .comp_ready_pulse(comp_rdy1), .sumchk_ready_pulse(sum_rdy1),
    .en_comp(en_comp1), .en_sumchk(en_sum1), .id(id1), .cur_layer(cur1),
    .busy(busy1), .ready_pulse(rp1), .ready(ready1), .err(err1)
  );

  // Layer models: answer each enable k cycles later; drop_c3 silences layers.
  int         k3 = 5;
  int         k1 = 2;
  int         due_c3[3] = '{-1, -1, -1};
  int         due_s3[3] = '{-1, -1, -1};
  int         due_c1 = -1;
  int         due_s1 = -1;
  logic [2:0] drop_c3 = '0;
  logic [2:0] inj_c3 = '0;
  logic [2:0] inj_s3 = '0;
  logic [2:0] resp_c3 = '0;
  logic [2:0] resp_s3 = '0;
  logic [0:0] resp_c1 = '0;
  logic [0:0] resp_s1 = '0;

  assign comp_rdy3 = resp_c3 | inj_c3;
  assign sum_rdy3  = resp_s3 | inj_s3;
  assign comp_rdy1 = resp_c1;
  assign sum_rdy1  = resp_s1;

  always @(posedge clk) begin
    #1;
    for (int l = 0; l < 3; l++) begin
      if (!rstb) begin
        due_c3[l] = -1;
        due_s3[l] = -1;
      end else begin
        if (en_comp3[l] && !drop_c3[l]) due_c3[l] = cyc + k3;
        if (en_sum3[l]) due_s3[l] = cyc + k3;
      end
      resp_c3[l] = (due_c3[l] == cyc);
      resp_s3[l] = (due_s3[l] == cyc);
    end
    if (!rstb) begin
      due_c1 = -1;
      due_s1 = -1;
    end else begin
      if (en_comp1[0]) due_c1 = cyc + k1;
      if (en_sum1[0]) due_s1 = cyc + k1;
    end
    resp_c1[0] = (due_c1 == cyc);
    resp_s1[0] = (due_s1 == cyc);
  end

  // Scoreboard queues and monitors
  ev_t q3[$];
  ev_t q1[$];
  ev_t obs3, exp3, obs1, exp1;

  function automatic int lowbit(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(negedge clk) begin
    if (rstb) begin
      if (en_comp3 != '0 || en_sum3 != '0) begin
        tests++;
        if ($countones({en_comp3, en_sum3}) != 1) begin
          fails++;
          $display("[TB] FAIL onehot3: en_comp=%b en_sumchk=%b, required exactly one bit set", en_comp3, en_sum3);
        end
        obs3.kind  = (en_comp3 != '0) ? 2'd0 : 2'd1;
        obs3.layer = lowbit(8'(en_comp3 | en_sum3));
        obs3.at    = cyc;
        tests++;
        if (q3.size() == 0) begin
          fails++;
          $display("[TB] FAIL sb3: got kind=%0d layer=%0d cycle=%0d, required no event", obs3.kind, obs3.layer, obs3.at);
        end else begin
          exp3 = q3.pop_front();
          if (obs3 !== exp3) begin
            fails++;
            $display("[TB] FAIL sb3: got kind=%0d layer=%0d cycle=%0d, required kind=%0d layer=%0d cycle=%0d",
                     obs3.kind, obs3.layer, obs3.at, exp3.kind, exp3.layer, exp3.at);
          end
        end
      end
      if (rp3) begin
        obs3.kind = 2'd2; obs3.layer = 0; obs3.at = cyc;
        tests++;
        if (q3.size() == 0) begin
          fails++;
          $display("[TB] FAIL sb3: got ready_pulse cycle=%0d, required no event", cyc);
        end else begin
          exp3 = q3.pop_front();
          if (obs3 !== exp3) begin
            fails++;
            $display("[TB] FAIL sb3: got ready_pulse cycle=%0d, required kind=%0d layer=%0d cycle=%0d",
                     cyc, exp3.kind, exp3.layer, exp3.at);
          end
        end
      end
      if (en_comp1 != '0 || en_sum1 != '0 || rp1) begin
        obs1.kind  = rp1 ? 2'd2 : ((en_comp1 != '0) ? 2'd0 : 2'd1);
        obs1.layer = 0;
        obs1.at    = cyc;
        tests++;
        if (q1.size() == 0) begin
          fails++;
          $display("[TB] FAIL sb1: got kind=%0d cycle=%0d, required no event", obs1.kind, obs1.at);
        end else begin
          exp1 = q1.pop_front();
          if (obs1 !== exp1 || (en_comp1 != '0 && en_sum1 != '0)) begin
            fails++;
            $display("[TB] FAIL sb1: got kind=%0d cycle=%0d en=%b/%b, required kind=%0d cycle=%0d",
                     obs1.kind, obs1.at, en_comp1, en_sum1, exp1.kind, exp1.at);
          end
        end
      end
    end
  end

  // Expected events for a full run started at cycle t with latency k over n layers.
  task automatic push_run(input int which, input int t, input int k, input int n);
    ev_t e;
    for (int i = 0; i < n; i++) begin
      e.kind = 2'd0; e.layer = i; e.at = t + 1 + i * (k + 1);
      if (which == 3) q3.push_back(e); else q1.push_back(e);
    end
    for (int j = 0; j < n; j++) begin
      e.kind = 2'd1; e.layer = n - 1 - j; e.at = t + 1 + (n + j) * (k + 1);
      if (which == 3) q3.push_back(e); else q1.push_back(e);
    end
    e.kind = 2'd2; e.layer = 0; e.at = t + 1 + 2 * n * (k + 1);
    if (which == 3) q3.push_back(e); else q1.push_back(e);
  endtask

  task automatic push_one(input logic [1:0] kind, input int layer, input int at);
    ev_t e;
    e.kind = kind; e.layer = layer; e.at = at;
    q3.push_back(e);
  endtask

  task automatic goto_cycle(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start3(input int t, input logic [31:0] v);
    goto_cycle(t);
    id_in3 = v;
    start3 = 1'b1;
    goto_cycle(t + 1);
    start3 = 1'b0;
    id_in3 = 32'hDEAD_BEEF;
  endtask

  task automatic drain3(input int budget);
    int n = 0;
    while (q3.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    tests++;
    if (q3.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain3: %0d events still pending, required 0", q3.size());
      q3.delete();
    end
  endtask

  task automatic test_reset();
    #2 rstb = 1'b0;
    goto_cycle(2);
    tests++;
    if ({en_comp3, en_sum3, id3, cur3, busy3, rp3, ready3, err3} !== '0) begin
      fails++;
      $display("[TB] FAIL reset3: outputs=%h, required 0", {en_comp3, en_sum3, id3, cur3, busy3, rp3, ready3, err3});
    end
    tests++;
    if ({en_comp1, en_sum1, id1, cur1, busy1, rp1, ready1, err1} !== '0) begin
      fails++;
      $display("[TB] FAIL reset1: outputs=%h, required 0", {en_comp1, en_sum1, id1, cur1, busy1, rp1, ready1, err1});
    end
    goto_cycle(3);
    rstb = 1'b1;
  endtask

  task automatic check_done3(input string name, input logic [31:0] idv);
    tests++;
    if (ready3 !== 1'b1 || busy3 !== 1'b0 || cur3 !== 2'd0 || id3 !== idv || err3 !== 1'b0) begin
      fails++;
      $display("[TB] FAIL %s: ready=%b busy=%b cur=%0d id=%h err=%b, required 1 0 0 %h 0",
               name, ready3, busy3, cur3, id3, err3, idv);
    end
  endtask

  task automatic test_basic_run();
    push_run(3, 10, 5, 3);
    pulse_start3(10, 32'h1234);
    tests++;
    if (busy3 !== 1'b1 || ready3 !== 1'b0 || id3 !== 32'h1234) begin
      fails++;
      $display("[TB] FAIL t1_start: busy=%b ready=%b id=%h, required 1 0 00001234", busy3, ready3, id3);
    end
    drain3(60);
    check_done3("t1_done", 32'h1234);
    goto_cycle(cyc + 3);
    tests++;
    if (ready3 !== 1'b1) begin
      fails++;
      $display("[TB] FAIL t1_ready_hold: ready=%b, required 1", ready3);
    end
  endtask

  task automatic test_ignored_inputs();
    int t = cyc + 2;
    push_run(3, t, 5, 3);
    pulse_start3(t, 32'h5678);
    goto_cycle(t + 2);
    inj_c3 = 3'b100;
    inj_s3 = 3'b001;
    goto_cycle(t + 3);
    inj_c3 = '0;
    inj_s3 = '0;
    id_in3 = 32'hBEEF;
    start3 = 1'b1;
    goto_cycle(t + 4);
    start3 = 1'b0;
    goto_cycle(t + 37);
    start3 = 1'b1;
    goto_cycle(t + 38);
    start3 = 1'b0;
    drain3(60);
    goto_cycle(t + 42);
    check_done3("t2_done", 32'h5678);
  endtask

  task automatic test_back_to_back();
    int t = cyc + 2;
    k3 = 0;
    push_run(3, t, 0, 3);
    pulse_start3(t, 32'hAAAA_0003);
    tests++;
    if (ready3 !== 1'b0 || busy3 !== 1'b1) begin
      fails++;
      $display("[TB] FAIL t3_start: ready=%b busy=%b, required 0 1", ready3, busy3);
    end
    drain3(20);
    check_done3("t3_done", 32'hAAAA_0003);
    k3 = 5;
  endtask

  task automatic test_reset_midrun();
    int t = cyc + 2;
    push_one(2'd0, 0, t + 1);
    push_one(2'd0, 1, t + 7);
    push_one(2'd0, 2, t + 13);
    push_one(2'd1, 2, t + 19);
    push_one(2'd1, 1, t + 25);
    pulse_start3(t, 32'h4444);
    goto_cycle(t + 28);
    rstb = 1'b0;
    #2;
    tests++;
    if ({en_comp3, en_sum3, id3, cur3, busy3, rp3, ready3, err3} !== '0) begin
      fails++;
      $display("[TB] FAIL t4_async: outputs=%h, required 0", {en_comp3, en_sum3, id3, cur3, busy3, rp3, ready3, err3});
    end
    tests++;
    if (q3.size() != 0) begin
      fails++;
      $display("[TB] FAIL t4_prefix: %0d events pending, required 0", q3.size());
      q3.delete();
    end
    goto_cycle(t + 34);
    rstb = 1'b1;
    push_run(3, t + 38, 5, 3);
    pulse_start3(t + 38, 32'h4545);
    drain3(60);
    check_done3("t4_done", 32'h4545);
  endtask

`ifdef LAYER_SEQ_WDOG_EN
  task automatic test_watchdog();
    int t = cyc + 2;
    drop_c3 = 3'b010;
    push_one(2'd0, 0, t + 1);
    push_one(2'd0, 1, t + 7);
    pulse_start3(t, 32'h0077);
    goto_cycle(t + 22);
    tests++;
    if (err3 !== 1'b0 || busy3 !== 1'b1) begin
      fails++;
      $display("[TB] FAIL t5_early: err=%b busy=%b, required 0 1", err3, busy3);
    end
    goto_cycle(t + 23);
    tests++;
    if (err3 !== 1'b1 || busy3 !== 1'b0 || cur3 !== 2'd1 || ready3 !== 1'b0) begin
      fails++;
      $display("[TB] FAIL t5_err: err=%b busy=%b cur=%0d ready=%b, required 1 0 1 0", err3, busy3, cur3, ready3);
    end
    goto_cycle(t + 30);
    tests++;
    if (err3 !== 1'b1) begin
      fails++;
      $display("[TB] FAIL t5_hold: err=%b, required 1", err3);
    end
    drop_c3 = '0;
    push_run(3, t + 30, 5, 3);
    pulse_start3(t + 30, 32'h0099);
    tests++;
    if (err3 !== 1'b0 || busy3 !== 1'b1) begin
      fails++;
      $display("[TB] FAIL t5_restart: err=%b busy=%b, required 0 1", err3, busy3);
    end
    drain3(60);
    check_done3("t5_done", 32'h0099);
  endtask
`else
  task automatic test_watchdog();
    int t = cyc + 2;
    drop_c3 = 3'b010;
    push_one(2'd0, 0, t + 1);
    push_one(2'd0, 1, t + 7);
    pulse_start3(t, 32'h0077);
    goto_cycle(t + 60);
    tests++;
    if (err3 !== 1'b0 || busy3 !== 1'b1 || cur3 !== 2'd1 || q3.size() != 0) begin
      fails++;
      $display("[TB] FAIL t5_nowdog: err=%b busy=%b cur=%0d pending=%0d, required 0 1 1 0",
               err3, busy3, cur3, q3.size());
      q3.delete();
    end
    rstb = 1'b0;
    goto_cycle(t + 62);
    rstb = 1'b1;
    drop_c3 = '0;
    goto_cycle(t + 64);
    tests++;
    if (busy3 !== 1'b0 || ready3 !== 1'b0 || err3 !== 1'b0) begin
      fails++;
      $display("[TB] FAIL t5_abort: busy=%b ready=%b err=%b, required 0 0 0", busy3, ready3, err3);
    end
  endtask
`endif

  task automatic test_single_layer();
    int t = cyc + 2;
    int n = 0;
    push_run(1, t, 2, 1);
    goto_cycle(t);
    id_in1 = 32'h0101;
    start1 = 1'b1;
    goto_cycle(t + 1);
    start1 = 1'b0;
    while (q1.size() != 0 && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    tests++;
    if (q1.size() != 0) begin
      fails++;
      $display("[TB] FAIL t6_drain: %0d events pending, required 0", q1.size());
      q1.delete();
    end
    goto_cycle(t + 10);
    tests++;
    if (ready1 !== 1'b1 || busy1 !== 1'b0 || cur1 !== 1'b0 || id1 !== 32'h0101) begin
      fails++;
      $display("[TB] FAIL t6_done: ready=%b busy=%b cur=%0d id=%h, required 1 0 0 00000101",
               ready1, busy1, cur1, id1);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_basic_run();
    test_ignored_inputs();
    test_back_to_back();
    test_reset_midrun();
    test_watchdog();
    test_single_layer();
    goto_cycle(cyc + 3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
